// File: rtl/overlay_pkg.sv
// overlay_pkg: shared definitions for the overlay mode controller.
//   state_e    - controller FSM state encoding (SHOWN / HIDDEN / PEND)
//   MODE_W     - width of the overlay mode index
//   step_mode  - wrapping increment/decrement of a mode index
package overlay_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [1:0] {
        ST_SHOWN  = 2'd0,
        ST_HIDDEN = 2'd1,
        ST_PEND   = 2'd2
    } state_e;

    // Move one step up or down through modes 0..max_m, wrapping at both ends.
    function automatic logic [MODE_W-1:0] step_mode(
        input logic [MODE_W-1:0] m,
        input logic              up,
        input logic [MODE_W-1:0] max_m
    );
        if (up) begin
            return (m == max_m) ? '0 : m + 1'b1;
        end
        return (m == '0) ? max_m : m - 1'b1;
    endfunction

endpackage

// File: rtl/overlay_ctrl_btn_debounce.sv
// btn_debounce: synchronizer, debounce filter and press detector for one
// raw pushbutton.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   btn_i   - raw asynchronous button, high = pressed
//   press_o - one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        // The counter measures how long the synchronized level has disagreed
        // with the accepted level; agreeing again means the level changed
        // back, which restarts the measurement.
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            deb_d   = sync2_q;
            cnt_d   = '0;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/overlay_ctrl.sv
// overlay_ctrl: selects an overlay mode with up/down buttons, commits the
// selection on the next vsync rising edge and shows the overlay for
// SHOW_CNT cycles after each commit.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   btn_up_i - raw up button, high = pressed
//   btn_dn_i - raw down button, high = pressed
//   vs_i     - vertical sync, synchronous to clk_i
//   mode_o   - committed mode index
//   en_o     - overlay enable
//   commit_o - one-cycle pulse on the cycle mode_o updates
module overlay_ctrl
    import overlay_pkg::*;
#(
    parameter int DEB_CNT  = 1000000,
    parameter int SHOW_CNT = 200000000,
    parameter int NMODES   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_up_i,
    input  logic              btn_dn_i,
    input  logic              vs_i,
    output logic [MODE_W-1:0] mode_o,
    output logic              en_o,
    output logic              commit_o
);

    localparam int SCNT_W = $clog2(SHOW_CNT + 1);
    localparam logic [SCNT_W-1:0] SHOW_LAST = SCNT_W'(SHOW_CNT - 1);
    localparam logic [SCNT_W-1:0] SHOW_SAT  = SCNT_W'(SHOW_CNT);
    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NMODES - 1);

    logic up_ev, dn_ev, ev, vs_rise;

    state_e            state_q, state_d;
    logic [MODE_W-1:0] pending_q, pending_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              commit_q, commit_d;
    logic              en_q, en_d;
    logic              vs_q;
    logic [SCNT_W-1:0] show_cnt_q, show_cnt_d;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_up_i),
        .press_o (up_ev)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_dn_i),
        .press_o (dn_ev)
    );

    // Simultaneous up and down presses cancel each other.
    assign ev      = up_ev ^ dn_ev;
    assign vs_rise = vs_i & ~vs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_SHOWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SHOWN: begin
                if (ev) begin
                    state_d = ST_PEND;
                end else if (show_cnt_q == SHOW_LAST) begin
                    state_d = ST_HIDDEN;
                end
            end
            ST_HIDDEN: begin
                if (ev) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (vs_rise) begin
                    state_d = ST_SHOWN;
                end
            end
            default: state_d = ST_SHOWN;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (ev) begin
            pending_d = step_mode(pending_q, up_ev, MODE_MAX);
        end
        // A commit takes the pending value including any event of this cycle.
        commit_d   = (state_q == ST_PEND) && vs_rise;
        mode_d     = commit_d ? pending_d : mode_q;
        show_cnt_d = show_cnt_q;
        if (commit_d) begin
            show_cnt_d = '0;
        end else if ((state_q == ST_SHOWN) && (show_cnt_q != SHOW_SAT)) begin
            show_cnt_d = show_cnt_q + 1'b1;
        end
        // Registered from the next state so en_o follows state_q exactly.
        en_d = (state_d != ST_HIDDEN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            mode_q     <= '0;
            commit_q   <= 1'b0;
            en_q       <= 1'b1;
            vs_q       <= 1'b0;
            show_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            commit_q   <= commit_d;
            en_q       <= en_d;
            vs_q       <= vs_i;
            show_cnt_q <= show_cnt_d;
        end
    end

    assign mode_o   = mode_q;
    assign en_o     = en_q;
    assign commit_o = commit_q;

endmodule

// File: doc/overlay_ctrl.md
OVERLAY_CTRL -- requirements
Module: overlay_ctrl

Interface
REQ-001 SHALL have parameter DEB_CNT, default 1000000, button-stable cycles required before a press is accepted.
REQ-002 SHALL have parameter SHOW_CNT, default 200000000, cycles the overlay stays enabled after a mode commit.
REQ-003 SHALL have parameter NMODES, default 8, number of modes (2..8).
REQ-004 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port btn_up_i, input, 1, raw asynchronous pushbutton, high = pressed.
REQ-007 SHALL have port btn_dn_i, input, 1, raw asynchronous pushbutton, high = pressed.
REQ-008 SHALL have port vs_i, input, 1, frame vertical sync, already synchronous to clk_i, high during vsync.
REQ-009 SHALL have port mode_o, output, 3, committed overlay mode index.
REQ-010 SHALL have port en_o, output, 1, overlay pattern enable.
REQ-011 SHALL have port commit_o, output, 1, one-cycle pulse on the cycle mode_o updates.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL debounce each synchronized button with its own counter: clear on any change of level, accept the level once it has been stable for DEB_CNT consecutive cycles.
REQ-014 SHALL generate a press event on a debounced 0->1 transition only; a held button SHALL produce exactly one event.
REQ-015 SHALL, on an up event, set the pending mode to pending+1, wrapping NMODES-1 -> 0; on a down event, set it to pending-1, wrapping 0 -> NMODES-1.
REQ-016 SHALL ignore both events when up and down events occur in the same cycle.
REQ-017 SHALL have FSM states SHOWN, HIDDEN and PEND.
REQ-018 SHALL, in SHOWN or HIDDEN, go to PEND on any accepted event.
REQ-019 SHALL, in PEND, stay put on further accepted events, with only the pending mode updating.
REQ-020 SHALL leave PEND only on the rising edge of vs_i (vs_i high, previous cycle low).
REQ-021 SHALL, on that rising edge, in the same registered update: copy the pending mode to mode_o, pulse commit_o, load the show counter with 0, and enter SHOWN.
REQ-022 SHALL, in SHOWN, increment the show counter each cycle; when it reaches SHOW_CNT-1 it SHALL enter HIDDEN.
REQ-023 SHALL drive en_o high in SHOWN and PEND and low in HIDDEN, registered directly from the state.
REQ-024 SHALL give a commit even when the pending mode equals mode_o, which restarts the timeout.
REQ-025 SHALL, when an event and a vs rising edge coincide while in PEND, commit the updated pending value.
REQ-026 SHALL, when an event coincides with a vs rising edge in SHOWN or HIDDEN, enter PEND with no commit that cycle.
REQ-027 SHALL size the show counter to $clog2(SHOW_CNT+1) bits, where it saturates; it SHALL never wrap.

Reset
REQ-028 SHALL, on reset, set mode_o=0, pending=0, commit_o=0, state=SHOWN, en_o=1, counters=0 and the synchronizer/debounced levels=0.
REQ-029 SHALL make reset dominate all inputs, and SHALL discard any pending change on a mid-PEND reset.

Structure
REQ-030 SHALL place the FSM state encoding and the mode width constant (3) in a shared package overlay_pkg, which the overlay datapath also uses.
REQ-031 SHALL implement the synchronizer, debounce and edge detect in one sub-module, btn_debounce, instanced once per button.

Verification
REQ-032 With DEB_CNT=4, SHOW_CNT=20 and reset released, bench SHALL check en_o=1, mode_o=0, and en_o=0 exactly 20 cycles after the reset release.
REQ-033 With btn_up high for 2 cycles, then low, bench SHALL check no event; with it high for 10 cycles, then vs_i rising, bench SHALL check commit_o is pulsed once, mode_o=1 and en_o=1.
REQ-034 With mode_o=0 and btn_dn pressed, then vs_i rising, bench SHALL check mode_o=NMODES-1=7; then 8 up presses and a vs rising edge SHALL give mode_o=7.
REQ-035 With up and down debounced on the same cycle, bench SHALL check the state is unchanged and no commit occurs.
REQ-036 With up pressed 3 times in PEND before vs_i, bench SHALL check a single commit with mode_o=3.
REQ-037 With rst_i asserted for 1 cycle while in PEND holding mode 5, bench SHALL check mode_o=0, no commit on the next vs rising edge, and en_o=1.
